// File: rtl/mem_pkg.sv
// Shared encodings for the sized data memory: access sizes and clear-FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte-lane mask and data replication,
// load lane select with sign/zero extension, and the alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        access,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rword[7:0];
      2'd1:    sel_byte = rword[15:8];
      2'd2:    sel_byte = rword[23:16];
      default: sel_byte = rword[31:24];
    endcase
    sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    lane_mask = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    case (size)
      SZ_BYTE: begin
        lane_mask = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sel_byte[7] & ~unsigned_ld}}, sel_byte};
      end
      SZ_HALF: begin
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sel_half[15] & ~unsigned_ld}}, sel_half};
      end
      SZ_WORD: begin
        lane_mask = 4'b1111;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

  // size=11 is always a fault, independent of address bits.
  assign misaligned = access &&
                      (((size == SZ_HALF) && addr_lo[0]) ||
                       ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
                       (size == 2'b11));

endmodule

// File: rtl/data_mem_sized.sv
// Word-organised data memory with byte/half/word access, fault detection,
// sticky error flag and a sequential post-reset clear engine.
module data_mem_sized
  import mem_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              err_sticky,
  output logic              dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  clr_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             clear_we;

  logic [IDX_W-1:0] word_idx;
  logic [3:0]       lane_mask;
  logic [31:0]      wdata_rep;
  logic [31:0]      rdata_ext;
  logic             access;
  logic             fault;
  logic             store_ok;

  assign access   = re | we;
  assign word_idx = addr[IDX_W+1:2];

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  assign out_of_range = access && (|addr[ADDR_W-1:IDX_W+2]);

  mem_lane_align u_align (
    .access      (access),
    .addr_lo     (addr[1:0]),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .wdata       (wdata),
    .rword       (mem[word_idx]),
    .lane_mask   (lane_mask),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  assign fault     = misaligned | out_of_range;
  assign busy      = (state_q == CLEAR);
  assign store_ok  = we && !busy && !fault;
  assign rdata     = (re && !busy && !fault) ? rdata_ext : 32'h0;
  assign dbg_state = logic'(state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
      idx_q      <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (!busy && fault) err_sticky <= 1'b1;
    end
  end

  // Leaving CLEAR acts as the done flag, so the index never wraps into a second pass.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clear_we = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        if (idx_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
        else                            idx_d   = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[idx_q] <= 32'h0;
    end else if (store_ok) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) mem[word_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized (DEPTH=64): clear sequence, sized loads and
// stores, faults, back-to-back stores and reset during clear.
module tb_data_mem_sized;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        misaligned;
  logic        out_of_range;
  logic        err_sticky;
  logic        dbg_state;

  int n_vec;
  int n_err;

  data_mem_sized #(.DEPTH(64), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addr         (addr),
    .re           (re),
    .we           (we),
    .size         (size),
    .unsigned_ld  (unsigned_ld),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .err_sticky   (err_sticky),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    @(negedge clk);
    addr = a; size = sz; wdata = d; we = 1'b1; re = 1'b0;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic u);
    @(negedge clk);
    addr = a; size = sz; unsigned_ld = u; re = 1'b1; we = 1'b0;
    #1;
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_reset;
    int cnt;
    reset_n = 1'b0; re = 1'b1; we = 1'b0; addr = 32'h10; size = W;
    unsigned_ld = 1'b0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b exp 1", busy); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err_sticky); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got %b exp 0", dbg_state); end
    addr = 32'h6;
    #1;
    n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL reset_misaligned got %b exp 1", misaligned); end
    re = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      // store and a faulted store attempted during the clear
      if (cnt == 10) begin we = 1'b1; addr = 32'h10; size = W; wdata = 32'hDEADBEEF; end
      if (cnt == 11) begin addr = 32'h6; end
      if (cnt == 12) begin we = 1'b0; end
    end
    n_vec++; if (cnt !== 64) begin n_err++; $display("FAIL clear_len got %0d exp 64", cnt); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL clear_err got %b exp 0", err_sticky); end
    n_vec++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL clear_done_state got %b exp 1", dbg_state); end
    for (int i = 0; i < 64; i++) begin
      ld(i * 4, W, 1'b0);
      n_vec++;
      if (rdata !== 32'h0) begin n_err++; $display("FAIL clear_word[%0d] got %h exp 0", i, rdata); end
    end
  endtask

  task automatic test_word_byte;
    st(32'h10, W, 32'h11223344);
    ld(32'h13, B, 1'b0);
    n_vec++; if (rdata !== 32'h00000011) begin n_err++; $display("FAIL lb_13 got %h exp 00000011", rdata); end
    ld(32'h10, B, 1'b0);
    n_vec++; if (rdata !== 32'h00000044) begin n_err++; $display("FAIL lb_10 got %h exp 00000044", rdata); end
    ld(32'h12, H, 1'b0);
    n_vec++; if (rdata !== 32'h00001122) begin n_err++; $display("FAIL lh_12 got %h exp 00001122", rdata); end
    ld(32'h10, W, 1'b1);
    n_vec++; if (rdata !== 32'h11223344) begin n_err++; $display("FAIL lw_10 got %h exp 11223344", rdata); end
    // simultaneous load and store: pre-edge data, then new data after the edge
    @(negedge clk);
    addr = 32'h10; size = W; wdata = 32'hCAFEF00D; we = 1'b1; re = 1'b1; #1;
    n_vec++; if (rdata !== 32'h11223344) begin n_err++; $display("FAIL rw_pre got %h exp 11223344", rdata); end
    @(posedge clk); #1; we = 1'b0;
    n_vec++; if (rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL rw_post got %h exp cafef00d", rdata); end
    re = 1'b0; #1;
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL re0 got %h exp 0", rdata); end
  endtask

  task automatic test_sb;
    st(32'h21, B, 32'h123456FF);
    ld(32'h20, W, 1'b0);
    n_vec++; if (rdata !== 32'h0000FF00) begin n_err++; $display("FAIL sb_word got %h exp 0000ff00", rdata); end
    ld(32'h21, B, 1'b0);
    n_vec++; if (rdata !== 32'hFFFFFFFF) begin n_err++; $display("FAIL lb_21 got %h exp ffffffff", rdata); end
    ld(32'h21, B, 1'b1);
    n_vec++; if (rdata !== 32'h000000FF) begin n_err++; $display("FAIL lbu_21 got %h exp 000000ff", rdata); end
  endtask

  task automatic test_sh;
    st(32'h32, H, 32'hABCD8001);
    ld(32'h32, H, 1'b0);
    n_vec++; if (rdata !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_32 got %h exp ffff8001", rdata); end
    ld(32'h32, H, 1'b1);
    n_vec++; if (rdata !== 32'h00008001) begin n_err++; $display("FAIL lhu_32 got %h exp 00008001", rdata); end
    ld(32'h30, W, 1'b1);
    n_vec++; if (rdata !== 32'h80010000) begin n_err++; $display("FAIL lw_30 got %h exp 80010000", rdata); end
    ld(32'h30, H, 1'b0);
    n_vec++; if (rdata !== 32'h00000000) begin n_err++; $display("FAIL lh_30 got %h exp 0", rdata); end
  endtask

  task automatic test_faults;
    ld(32'h6, W, 1'b0);
    re = 1'b0; #1;
    n_vec++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL idle_misaligned got %b exp 0", misaligned); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL pre_err got %b exp 0", err_sticky); end
    @(negedge clk);
    addr = 32'h6; size = W; wdata = 32'h5A5A5A5A; we = 1'b1; #1;
    n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL sw_06_misaligned got %b exp 1", misaligned); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL err_before_edge got %b exp 0", err_sticky); end
    @(posedge clk); #1; we = 1'b0;
    n_vec++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL err_after_edge got %b exp 1", err_sticky); end
    ld(32'h4, W, 1'b0);
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL sw_06_nowrite got %h exp 0", rdata); end
    ld(32'h12, W, 1'b0);
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL lw_12_rdata got %h exp 0", rdata); end
    // 0x110 aliases word 4 (nonzero) in the index bits
    ld(32'h110, W, 1'b0);
    n_vec++; if (out_of_range !== 1'b1) begin n_err++; $display("FAIL oor_flag got %b exp 1", out_of_range); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL oor_rdata got %h exp 0", rdata); end
    ld(32'h100, B, 1'b0);
    n_vec++; if (out_of_range !== 1'b1) begin n_err++; $display("FAIL oor_100 got %b exp 1", out_of_range); end
    ld(32'hFC, W, 1'b0);
    n_vec++; if (out_of_range !== 1'b0) begin n_err++; $display("FAIL inrange_fc got %b exp 0", out_of_range); end
    ld(32'h10, 2'b11, 1'b0);
    n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL size11 got %b exp 1", misaligned); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL size11_rdata got %h exp 0", rdata); end
    ld(32'h33, H, 1'b0);
    n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL lh_33 got %b exp 1", misaligned); end
    st(32'h120, W, 32'h5A5A5A5A);
    st(32'h23, H, 32'h00007777);
    ld(32'h20, W, 1'b0);
    n_vec++; if (rdata !== 32'h0000FF00) begin n_err++; $display("FAIL fault_store_dropped got %h exp 0000ff00", rdata); end
  endtask

  task automatic test_back_to_back;
    st(32'h40, B, 32'h000000AA);
    st(32'h41, B, 32'h000000BB);
    st(32'h42, B, 32'h000000CC);
    st(32'h43, B, 32'h000000DD);
    ld(32'h40, W, 1'b0);
    n_vec++; if (rdata !== 32'hDDCCBBAA) begin n_err++; $display("FAIL b2b_word got %h exp ddccbbaa", rdata); end
    ld(32'h42, H, 1'b0);
    n_vec++; if (rdata !== 32'hFFFFDDCC) begin n_err++; $display("FAIL b2b_lh got %h exp ffffddcc", rdata); end
    st(32'h40, H, 32'h00001234);
    ld(32'h40, W, 1'b0);
    n_vec++; if (rdata !== 32'hDDCC1234) begin n_err++; $display("FAIL b2b_sh got %h exp ddcc1234", rdata); end
    ld(32'h41, B, 1'b0);
    n_vec++; if (rdata !== 32'h00000012) begin n_err++; $display("FAIL b2b_lb got %h exp 00000012", rdata); end
  endtask

  task automatic test_mid_clear_reset;
    int cnt;
    @(negedge clk); re = 1'b0; we = 1'b0;
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy got %b exp 1", busy); end
    reset_n = 1'b0; #1;
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL midclear_state got %b exp 0", dbg_state); end
    @(negedge clk); reset_n = 1'b1;
    wait_clear(cnt);
    n_vec++; if (cnt !== 64) begin n_err++; $display("FAIL midclear_len got %0d exp 64", cnt); end
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL midclear_err got %b exp 0", err_sticky); end
    ld(32'h40, W, 1'b0);
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL midclear_word got %h exp 0", rdata); end
    ld(32'h10, W, 1'b0);
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL midclear_word4 got %h exp 0", rdata); end
    st(32'hFC, W, 32'h87654321);
    ld(32'hFE, H, 1'b1);
    n_vec++; if (rdata !== 32'h00008765) begin n_err++; $display("FAIL top_word_lhu got %h exp 00008765", rdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_word_byte();
    test_sb();
    test_sh();
    test_faults();
    test_back_to_back();
    test_mid_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
